// File: rtl/dbus_mem.sv
// dbus_mem: word RAM plus timer/status registers on a
// cs/we/ack data bus with a configurable wait-state count.
module dbus_mem #(
  parameter int AW   = 12,
  parameter int WAIT = 0
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_dat,
  output logic [15:0] o_dat,
  output logic        o_ack,
  input  logic        i_we,
  input  logic        i_cs,
  output logic        o_irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_e;

  localparam logic [15:0] WLOAD =
    (WAIT > 0) ? 16'(WAIT - 1) : 16'd0;

  state_e      state_q;
  logic [15:0] wcnt_q;
  logic [15:0] addr_q;
  logic [15:0] wdat_q;
  logic        we_q;
  logic        ack_q;
  logic [15:0] hold_q;
  logic [15:0] rdata_q;

  logic        en_q, ie_q, tf_q;
  logic        en_d, ie_d, tf_d;
  logic [15:0] reload_q, count_q;
  logic [15:0] reload_d, count_d;
  logic        tf_set;

  logic          in_ram;
  logic          commit;
  logic          wr_ctrl, wr_timer, wr_status;
  logic          rd_ack;
  logic [15:0]   rd_val;
  logic [AW-1:0] ra;
  logic [15:0]   mem [2**AW];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (i_cs) begin
            addr_q <= i_addr;
            wdat_q <= i_dat;
            we_q   <= i_we;
            if (WAIT > 0) begin
              state_q <= S_WAIT;
              wcnt_q  <= WLOAD;
            end else begin
              state_q <= S_ACK;
              ack_q   <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (wcnt_q == 16'd0) begin
            state_q <= S_ACK;
            ack_q   <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q - 16'd1;
          end
        end
        S_ACK:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ram    = (addr_q >> AW) == 16'd0;
  assign commit    = ack_q && we_q;
  assign rd_ack    = ack_q && !we_q;
  assign wr_ctrl   = commit && (addr_q == 16'hFF00);
  assign wr_timer  = commit && (addr_q == 16'hFF01);
  assign wr_status = commit && (addr_q == 16'hFF02);

  // With zero wait states the read must start on the sampling edge.
  assign ra = (state_q == S_IDLE) ? i_addr[AW-1:0]
                                  : addr_q[AW-1:0];

  always_ff @(posedge i_clk) begin
    if (commit && in_ram) begin
      mem[addr_q[AW-1:0]] <= wdat_q;
    end
    rdata_q <= mem[ra];
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      in_ram:               rd_val = rdata_q;
      addr_q == 16'hFF00:   rd_val = {14'd0, ie_q, en_q};
      addr_q == 16'hFF01:   rd_val = count_q;
      addr_q == 16'hFF02:   rd_val = {15'd0, tf_q};
      default:              rd_val = '0;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    en_d     = en_q;
    ie_d     = ie_q;
    tf_set   = 1'b0;
    if (en_q) begin
      if (count_q == 16'd0) begin
        count_d = reload_q;
        tf_set  = 1'b1;
      end else begin
        count_d = count_q - 16'd1;
      end
    end
    if (wr_timer) begin
      count_d  = wdat_q;
      reload_d = wdat_q;
    end
    if (wr_ctrl) begin
      en_d = wdat_q[0];
      ie_d = wdat_q[1];
    end
    tf_d = tf_q;
    if (wr_status && wdat_q[0]) tf_d = 1'b0;
    if (tf_set)                 tf_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q  <= '0;
      reload_q <= '0;
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      tf_q     <= 1'b0;
      hold_q   <= '0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      en_q     <= en_d;
      ie_q     <= ie_d;
      tf_q     <= tf_d;
      if (rd_ack) hold_q <= rd_val;
    end
  end

  assign o_dat = rd_ack ? rd_val : hold_q;
  assign o_ack = ack_q;
  assign o_irq = tf_q & ie_q;

endmodule

// File: tb/tb_dbus_mem.sv
// Bench for dbus_mem: one instance with no wait states and
// one with three, vector table, random RAM traffic, corners.
module tb_dbus_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        cs    [2];
  logic        we    [2];
  logic [15:0] addr  [2];
  logic [15:0] wdat  [2];
  logic [15:0] rdat  [2];
  logic        ack   [2];
  logic        irq   [2];

  int n_pass = 0;
  int n_tot  = 0;

  dbus_mem #(.AW(12), .WAIT(0)) u_w0 (
    .i_clk    (clk),
    .i_reset_n(rst_n[0]),
    .i_addr   (addr[0]),
    .i_dat    (wdat[0]),
    .o_dat    (rdat[0]),
    .o_ack    (ack[0]),
    .i_we     (we[0]),
    .i_cs     (cs[0]),
    .o_irq    (irq[0])
  );

  dbus_mem #(.AW(12), .WAIT(3)) u_w3 (
    .i_clk    (clk),
    .i_reset_n(rst_n[1]),
    .i_addr   (addr[1]),
    .i_dat    (wdat[1]),
    .o_dat    (rdat[1]),
    .o_ack    (ack[1]),
    .i_we     (we[1]),
    .i_cs     (cs[1]),
    .o_irq    (irq[1])
  );

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  vec_t        tv [18];
  logic [15:0] mdl [2][4096];
  logic [15:0] pool [8];
  logic [15:0] r, d1, d2, a;
  logic [15:0] v;
  int          lat, first, second, extra, saw, s;
  logic        w, unm;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic bus(input int sl, input logic wr,
                     input logic [15:0] ad,
                     input logic [15:0] dt,
                     output logic [15:0] rd,
                     output int lt);
    @(negedge clk);
    cs[sl]   = 1'b1;
    we[sl]   = wr;
    addr[sl] = ad;
    wdat[sl] = dt;
    @(posedge clk);
    lt = -1;
    rd = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      cs[sl] = 1'b0;
      if (ack[sl]) begin
        lt = n;
        rd = rdat[sl];
        break;
      end
    end
    if (lt < 0) begin
      n_tot++;
      $display("FAIL bus_timeout: addr %h no ack, want <=20", ad);
    end else begin
      @(posedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0;
      cs[i]    = 1'b0;
      we[i]    = 1'b0;
      addr[i]  = '0;
      wdat[i]  = '0;
    end
    tv[0]  = '{1'b1, 16'h0010, 16'h1234, 16'h0000};
    tv[1]  = '{1'b0, 16'h0010, 16'h0000, 16'h1234};
    tv[2]  = '{1'b1, 16'h0000, 16'hAAAA, 16'h0000};
    tv[3]  = '{1'b1, 16'h8000, 16'h5555, 16'h0000};
    tv[4]  = '{1'b0, 16'h8000, 16'h0000, 16'h0000};
    tv[5]  = '{1'b0, 16'h0000, 16'h0000, 16'hAAAA};
    tv[6]  = '{1'b1, 16'h0FFF, 16'hBEEF, 16'h0000};
    tv[7]  = '{1'b0, 16'h0FFF, 16'h0000, 16'hBEEF};
    tv[8]  = '{1'b1, 16'h1000, 16'h7777, 16'h0000};
    tv[9]  = '{1'b0, 16'h1000, 16'h0000, 16'h0000};
    tv[10] = '{1'b0, 16'h0000, 16'h0000, 16'hAAAA};
    tv[11] = '{1'b1, 16'hFF01, 16'h0005, 16'h0000};
    tv[12] = '{1'b0, 16'hFF01, 16'h0000, 16'h0005};
    tv[13] = '{1'b1, 16'hFF00, 16'hFFFC, 16'h0000};
    tv[14] = '{1'b0, 16'hFF00, 16'h0000, 16'h0000};
    tv[15] = '{1'b0, 16'hFF02, 16'h0000, 16'h0000};
    tv[16] = '{1'b0, 16'hFF03, 16'h0000, 16'h0000};
    tv[17] = '{1'b0, 16'hFF01, 16'h0000, 16'h0005};

    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_ack%0d", i), ack[i], 0);
      chk($sformatf("rst_dat%0d", i), rdat[i], 0);
      chk($sformatf("rst_irq%0d", i), irq[i], 0);
    end

    for (int i = 0; i < 18; i++) begin
      bus(0, tv[i].w, tv[i].a, tv[i].d, r, lat);
      chk($sformatf("vec%0d_lat", i), lat, 1);
      if (!tv[i].w)
        chk($sformatf("vec%0d_dat", i), r, tv[i].exp);
    end

    for (int i = 0; i < 8; i++)
      pool[i] = 16'($urandom_range(16'h0100, 16'h0FFF));
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        v = 16'($urandom);
        bus(k, 1'b1, pool[i], v, r, lat);
        mdl[k][pool[i][11:0]] = v;
      end
    end
    for (int i = 0; i < 150; i++) begin
      s   = int'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      unm = ($urandom_range(0, 7) == 0);
      a   = unm ? 16'($urandom_range(16'h1000, 16'hFEFF))
                : pool[$urandom_range(0, 7)];
      v   = 16'($urandom);
      bus(s, w, a, v, r, lat);
      chk($sformatf("rnd%0d_lat", i), lat, (s == 1) ? 4 : 1);
      if (!w)
        chk($sformatf("rnd%0d_dat@%h", i, a), r,
            unm ? 16'h0000 : mdl[s][a[11:0]]);
      else if (!unm)
        mdl[s][a[11:0]] = v;
    end

    // Timer: reload 3 gives a TF set every 4th edge after enable.
    bus(0, 1'b1, 16'hFF01, 16'h0003, r, lat);
    bus(0, 1'b1, 16'hFF00, 16'h0003, r, lat);
    for (int e = 0; e < 6; e++) begin
      @(negedge clk);
      chk($sformatf("tmr_irq_e%0d", e), irq[0], (e >= 4));
      @(posedge clk);
    end
    bus(0, 1'b1, 16'hFF02, 16'h0001, r, lat);
    @(negedge clk);
    chk("tf_set_wins", irq[0], 1);
    bus(0, 1'b1, 16'hFF02, 16'h0001, r, lat);
    @(negedge clk);
    chk("tf_cleared", irq[0], 0);
    @(negedge clk);
    chk("tf_reset_e12", irq[0], 1);
    bus(0, 1'b1, 16'hFF00, 16'h0000, r, lat);
    bus(0, 1'b1, 16'hFF02, 16'h0001, r, lat);
    bus(0, 1'b0, 16'hFF02, 16'h0000, r, lat);
    chk("status_rd", r, 0);
    chk("irq_off", irq[0], 0);

    bus(1, 1'b1, 16'h0040, 16'hBEEF, r, lat);
    chk("w3_wr_lat", lat, 4);
    @(negedge clk);
    cs[1]   = 1'b1;
    we[1]   = 1'b0;
    addr[1] = 16'h0040;
    first   = -1;
    second  = -1;
    extra   = 0;
    d1      = '0;
    d2      = '0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (ack[1]) begin
        if (first < 0) begin
          first = n;
          d1    = rdat[1];
        end else if (second < 0) begin
          second = n;
          d2     = rdat[1];
          cs[1]  = 1'b0;
        end else begin
          extra++;
        end
      end
    end
    cs[1] = 1'b0;
    chk("b2b_first", first, 4);
    chk("b2b_second", second, 9);
    chk("b2b_extra", extra, 0);
    chk("b2b_d1", d1, 16'hBEEF);
    chk("b2b_d2", d2, 16'hBEEF);

    bus(1, 1'b1, 16'h0020, 16'h1111, r, lat);
    @(negedge clk);
    cs[1]   = 1'b1;
    we[1]   = 1'b1;
    addr[1] = 16'h0020;
    wdat[1] = 16'h2222;
    @(negedge clk);
    cs[1]    = 1'b0;
    rst_n[1] = 1'b0;
    saw      = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (ack[1]) saw++;
    end
    chk("rst_mid_dat", rdat[1], 0);
    rst_n[1] = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (ack[1]) saw++;
    end
    chk("rst_mid_noack", saw, 0);
    bus(1, 1'b0, 16'h0020, 16'h0000, r, lat);
    chk("rst_mid_lat", lat, 4);
    chk("rst_mid_old", r, 16'h1111);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
